// File: rtl/gravity_control.sv
// Gravity-flip game controller: debounces the flip button, decides when a flip is
// legal from the player's height and the ground lines, and tracks run/dead state and score.
module gravity_control #(
    parameter int DB_LEN  = 3,
    parameter int FLOOR_Y = 420
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic [8:0]  height,
    input  logic [2:0]  lines,
    output logic        grav_dir,
    output logic        is_dead,
    output logic        running,
    output logic [15:0] score
);

    localparam int              CW      = $clog2(DB_LEN + 1);
    localparam logic [CW-1:0]   DB_MAX  = CW'(DB_LEN);
    localparam logic [8:0]      FLOOR_H = 9'(FLOOR_Y);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [1:0]     sync_reg;
    logic [CW-1:0]  db_cnt_reg, db_cnt_next;
    logic           press_reg;
    logic           grav_dir_reg, grav_dir_next;
    logic           is_dead_reg, running_reg;
    logic [15:0]    score_reg, score_next;
    logic           btn_s, grounded, fatal;

    assign btn_s = sync_reg[1];

    // Counter saturates while held, so press fires only once per hold.
    always_comb begin
        db_cnt_next = db_cnt_reg;
        if (!btn_s)
            db_cnt_next = '0;
        else if (db_cnt_reg != DB_MAX)
            db_cnt_next = db_cnt_reg + 1'b1;
    end

    always_comb begin
        if (!grav_dir_reg)
            grounded = (height == 9'd180 && lines[1]) || (height == 9'd300 && lines[2]);
        else
            grounded = (height == 9'd120 && lines[0]) || (height == 9'd240 && lines[1]);
    end

    assign fatal = (height >= FLOOR_H) || (height == 9'd0);

    always_comb begin
        state_next    = state_reg;
        grav_dir_next = grav_dir_reg;
        score_next    = score_reg;
        case (state_reg)
            IDLE: begin
                if (press_reg)
                    state_next = RUN;
            end
            RUN: begin
                if (score_reg != 16'hFFFF)
                    score_next = score_reg + 16'd1;
                // Death takes priority over a simultaneous legal flip.
                if (fatal)
                    state_next = DEAD;
                else if (press_reg && grounded)
                    grav_dir_next = ~grav_dir_reg;
            end
            DEAD: begin
                state_next = DEAD;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            sync_reg     <= '0;
            db_cnt_reg   <= '0;
            press_reg    <= 1'b0;
            grav_dir_reg <= 1'b0;
            is_dead_reg  <= 1'b0;
            running_reg  <= 1'b0;
            score_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            sync_reg     <= {sync_reg[0], btn};
            db_cnt_reg   <= db_cnt_next;
            press_reg    <= (db_cnt_next == DB_MAX) && (db_cnt_reg != DB_MAX);
            grav_dir_reg <= grav_dir_next;
            is_dead_reg  <= (state_next == DEAD);
            running_reg  <= (state_next == RUN);
            score_reg    <= score_next;
        end
    end

    assign grav_dir = grav_dir_reg;
    assign is_dead  = is_dead_reg;
    assign running  = running_reg;
    assign score    = score_reg;

endmodule

// File: doc/gravity_control.md
GRAVITY_CONTROL -- requirements
Module: gravity_control

Interface
REQ-001 The parameter DB_LEN SHALL default to 3 and set the number of consecutive cycles btn must be sampled high before a debounced press is recognised.
REQ-002 The parameter FLOOR_Y SHALL default to 420 and set the fall-off height threshold.
REQ-003 clk  input  1  game tick clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 btn  input  1  raw flip button, level, unsynchronised.
REQ-006 height  input  9  player top-left height from the movement stage.
REQ-007 lines  input  3  ground-present flags at player x: bit0 = 120, bit1 = 240, bit2 = 360.
REQ-008 grav_dir  output  1  gravity direction to the movement stage (0 down, 1 up), registered.
REQ-009 is_dead  output  1  player dead flag to the movement stage, registered.
REQ-010 running  output  1  high while in RUN, registered.
REQ-011 score  output  16  count of RUN cycles, registered.

Function
REQ-012 btn SHALL pass through a 2-flop synchroniser before any other use.
REQ-013 A debounce counter SHALL increment while the synchronised btn is 1, saturate at DB_LEN, and clear to 0 when it is 0.
REQ-014 press SHALL be a single-cycle pulse asserted on the cycle the debounce counter first reaches DB_LEN; holding btn produces no further pulses until btn is released to 0 for at least one synchronised cycle.
REQ-015 grounded SHALL be, when grav_dir=0: (height==180 & lines[1]) | (height==300 & lines[2]); when grav_dir=1: (height==120 & lines[0]) | (height==240 & lines[1]).
REQ-016 fatal SHALL be (height >= FLOOR_Y) | (height == 0); height wrap-around to 511 is therefore fatal.
REQ-017 The FSM SHALL have states IDLE, RUN, DEAD; IDLE is the reset state.
REQ-018 IDLE: outputs grav_dir=0, is_dead=0, running=0, score held; on press -> RUN with no gravity flip.
REQ-019 RUN: running=1; score increments by 1 each cycle, saturating at 16'hFFFF (no wrap).
REQ-020 RUN: on press with grounded=1 and fatal=0, grav_dir SHALL toggle on that edge, visible the next cycle.
REQ-021 RUN: a press with grounded=0 SHALL be discarded (no buffering, no later flip).
REQ-022 RUN: on fatal=1 -> DEAD; is_dead=1 from the next cycle.
REQ-023 Simultaneous fatal and grounded press in RUN: fatal wins; grav_dir SHALL NOT toggle.
REQ-024 DEAD: is_dead=1, running=0, grav_dir and score frozen; press ignored; DEAD exits only on reset.
REQ-025 Latency: btn rising to press is 2 (sync) + DB_LEN cycles; press to grav_dir change is 1 cycle.
REQ-026 grounded and fatal are combinational from current inputs; no input other than btn is registered before use.

Reset
REQ-027 On reset=0, asynchronously: state=IDLE, grav_dir=0, is_dead=0, running=0, score=0, synchroniser flops=0, debounce counter=0.
REQ-028 Reset asserted mid-RUN or in DEAD SHALL produce the same values as REQ-027 without waiting for clk.
REQ-029 After reset release, the first press requires btn to be sampled high for the full 2 + DB_LEN cycles.

Verification
REQ-030 Reset, btn held 1 for 6 cycles -> exactly one press; state RUN, running=1, grav_dir=0; score reaches 1 on the cycle after entering RUN.
REQ-031 RUN, height=180, lines=3'b010, press -> grav_dir=1 next cycle; then height=120, lines=3'b001, press -> grav_dir=0.
REQ-032 RUN, height=200, lines=3'b111, press -> grav_dir unchanged; later height=180 with no new press -> still unchanged.
REQ-033 RUN, height=420 -> is_dead=1 next cycle; height=0 from a fresh run -> is_dead=1; btn activity in DEAD -> no change to any output.
REQ-034 btn pulse of 2 cycles (shorter than DB_LEN) -> no press, state IDLE; reset asserted mid-RUN with score=37 -> score=0, grav_dir=0, is_dead=0 immediately.
REQ-035 score forced near saturation (run 65540 cycles) -> score holds at 16'hFFFF.
